generador_pulsos_rtc_param: RTL and testbench
=============================================

Name: generador_pulsos_rtc_param

Overview:
- Parametrised successor to the fixed RTC pulse-generation logic.
- Owns its phase counters, so no external count input is needed; timing comes from parameters.
- Drives the multiplexed address/data bus strobes of the RTC chip for single write, single read and burst read.
- Sits between the RTC control FSM (start/funcion/addr/data) and the RTC pins; it also returns read data and the RAM index for the register-copy memory.

Parameters:
- T_ADDR, 4, cycles of the address phase (>=1)
- T_DATA, 4, cycles of the data strobe phase (>=1)
- T_GAP, 2, idle cycles after each phase (>=1)
- N_BURST, 9, registers transferred by a burst read (1..16)
- CNT_W, 8, width of the internal phase counter; must hold max(T_ADDR,T_DATA,T_GAP)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request pulse, sampled only in IDLE
- funcion  in  2  00 nop, 01 single write, 10 single read, 11 burst read
- addr_in  in  8  RTC register address (burst start address)
- dato_wr_in  in  8  write data
- bus_dato_in  in  8  RTC bus read-back
- a_d_out  out  1  address/data select, 0 = address
- cs_out  out  1  chip select, active-low
- wr_out  out  1  write strobe, active-low
- rd_out  out  1  read strobe, active-low
- bus_oe_out  out  1  1 = drive bus_dato_out onto the RTC bus
- bus_dato_out  out  8  address or data being driven
- dato_leido_out  out  8  last captured read data
- dato_valido_out  out  1  1-cycle pulse when dato_leido_out is updated
- addr_RAM_out  out  4  burst index of the current transfer (0 for single)
- funcion_r_w_out  out  1  1 = current op is a read
- busy_out  out  1  high from the ADDR state through the DONE state
- done_out  out  1  1-cycle pulse at the end of an operation

Behaviour:
- All outputs are registered. Reset values:
  - a_d, cs, wr, rd = 1
  - bus_oe, busy, done, dato_valido, funcion_r_w = 0
  - bus_dato, dato_leido, addr_RAM = 0
- Reset mid-operation: the FSM goes to IDLE on the reset edge; all strobes are high and bus_oe = 0 on the next cycle. No done pulse is issued.
- FSM states: IDLE, ADDR, GAP1, DATA, GAP2, DONE.
- IDLE:
  - start=1 with funcion!=00 at edge k latches funcion, addr_in and dato_wr_in, and sets busy.
  - ADDR outputs appear from cycle k+1.
  - start with funcion=00, or start in any non-IDLE state, is ignored.
- ADDR (T_ADDR cycles): a_d=0, cs=0, wr=0, rd=1, bus_oe=1, bus_dato_out = current address.
- GAP1 (T_GAP cycles): a_d=1, cs=1, wr=1, rd=1, bus_oe=0.
- DATA (T_DATA cycles): a_d=1, cs=0.
  - Write: wr=0, bus_oe=1, bus_dato_out = latched data.
  - Read: rd=0, bus_oe=0. bus_dato_in is sampled at the edge ending the last DATA cycle; dato_leido_out updates and dato_valido_out pulses in the following cycle.
- GAP2 (T_GAP cycles): all strobes high, bus_oe=0.
  - Burst with index < N_BURST-1: the address and addr_RAM_out increment, then go to ADDR.
  - Otherwise go to DONE.
- Address arithmetic is 8-bit and wraps from 0xFF to 0x00.
- DONE (1 cycle): done_out=1, busy=1, strobes high; then IDLE with busy=0.
- Single-op length: T_ADDR+2*T_GAP+T_DATA cycles, plus 1 cycle of DONE.
- wr and rd are never low together.
- cs is high during every gap.

Optional Feature:
- Macro GEN_PULSOS_BURST_EN.
- Defined: funcion=11 performs a burst read of N_BURST registers as described above.
- Undefined: funcion=11 behaves exactly as a single read (10); addr_RAM_out stays 0; burst counter logic is not synthesised.

Test Plan:
- Reset: rst=1 for 2 cycles at any point -> a_d=cs=wr=rd=1, bus_oe=0, busy=0, done=0.
- Single write (defaults): start at edge 0, funcion=01, addr 0x0A, data 0x5C.
  - Cycles 1-4: a_d=0, cs=0, wr=0, bus=0x0A.
  - Cycles 5-6: all strobes high.
  - Cycles 7-10: cs=0, wr=0, bus=0x5C.
  - Cycles 11-12: all strobes high.
  - Cycle 13: done=1; cycle 14: busy=0.
- Single read: funcion=10, addr 0x04, bus_dato_in=0x37 during the DATA phase -> rd=0 in cycles 7-10, wr stays 1, dato_leido=0x37 and dato_valido=1 in cycle 11.
- Burst read with GEN_PULSOS_BURST_EN defined, addr 0xFE:
  - Exactly 9 dato_valido pulses.
  - Address sequence 0xFE, 0xFF, 0x00, ... 0x06.
  - addr_RAM_out runs 0..8; a single done pulse at the end.
- start pulses while busy=1, and start with funcion=00 while idle -> no new transaction and no done pulse.
- rst asserted in the DATA phase of a write -> strobes high on the next cycle, no done pulse; a new start afterwards completes normally.

Source files
------------

// File: rtl/generador_pulsos_rtc_param.sv
// Parametrised strobe generator for the multiplexed RTC bus: single write, single read and burst read.
// Optional burst support is compiled in with GEN_PULSOS_BURST_EN; without it funcion=11 is a single read.
module generador_pulsos_rtc_param #(
  parameter int T_ADDR  = 4,
  parameter int T_DATA  = 4,
  parameter int T_GAP   = 2,
  parameter int N_BURST = 9,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] funcion,
  input  logic [7:0] addr_in,
  input  logic [7:0] dato_wr_in,
  input  logic [7:0] bus_dato_in,
  output logic       a_d_out,
  output logic       cs_out,
  output logic       wr_out,
  output logic       rd_out,
  output logic       bus_oe_out,
  output logic [7:0] bus_dato_out,
  output logic [7:0] dato_leido_out,
  output logic       dato_valido_out,
  output logic [3:0] addr_RAM_out,
  output logic       funcion_r_w_out,
  output logic       busy_out,
  output logic       done_out
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_GAP1 = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_GAP2 = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(T_ADDR - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(T_DATA - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(T_GAP - 1);

  if (T_ADDR < 1 || T_DATA < 1 || T_GAP < 1 || N_BURST < 1 || N_BURST > 16 ||
      T_ADDR > 2**CNT_W || T_DATA > 2**CNT_W || T_GAP > 2**CNT_W) begin : g_param_chk
    $error("generador_pulsos_rtc_param: invalid parameter set");
  end

  logic [2:0]       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [7:0]       addr_r, addr_s;
  logic [7:0]       dato_r, dato_s;
  logic [1:0]       func_r, func_s;
  logic [3:0]       idx_s;
  logic             capture_s;
  logic             burst_more_s;

  logic       a_d_s, cs_s, wr_s, rd_s, oe_s, busy_s, done_s, rw_s;
  logic [7:0] bus_s;

`ifdef GEN_PULSOS_BURST_EN
  localparam logic [3:0] IDX_LAST = 4'(N_BURST - 1);
  logic [3:0] idx_r;

  assign burst_more_s = (func_r == 2'b11) && (idx_r != IDX_LAST);

  // Burst index: cleared while idle, advanced when GAP2 loops back to ADDR
  always_comb begin
    idx_s = idx_r;
    if (state_r == S_IDLE) begin
      idx_s = 4'd0;
    end else if ((state_r == S_GAP2) && (cnt_r == GAP_LAST) && burst_more_s) begin
      idx_s = idx_r + 4'd1;
    end else begin
      idx_s = idx_r;
    end
  end

  // Burst index register
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r <= 4'd0;
    end else begin
      idx_r <= idx_s;
    end
  end
`else
  assign burst_more_s = 1'b0;
  assign idx_s        = 4'd0;
`endif

  // Next-state, phase counter and latched transaction fields
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    addr_s    = addr_r;
    dato_s    = dato_r;
    func_s    = func_r;
    capture_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start && (funcion != 2'b00)) begin
          state_s = S_ADDR;
          cnt_s   = CNT_ZERO;
          addr_s  = addr_in;
          dato_s  = dato_wr_in;
          func_s  = funcion;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ADDR: begin
        if (cnt_r == ADDR_LAST) begin
          state_s = S_GAP1;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_GAP1: begin
        if (cnt_r == GAP_LAST) begin
          state_s = S_DATA;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt_r == DATA_LAST) begin
          state_s   = S_GAP2;
          cnt_s     = CNT_ZERO;
          capture_s = func_r[1];
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_GAP2: begin
        if (cnt_r != GAP_LAST) begin
          cnt_s = cnt_r + CNT_ONE;
        end else if (burst_more_s) begin
          state_s = S_ADDR;
          cnt_s   = CNT_ZERO;
          addr_s  = addr_r + 8'd1;
        end else begin
          state_s = S_DONE;
          cnt_s   = CNT_ZERO;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
        cnt_s   = CNT_ZERO;
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Pin decode from the next state so the registered pins line up with the state register
  always_comb begin
    a_d_s  = 1'b1;
    cs_s   = 1'b1;
    wr_s   = 1'b1;
    rd_s   = 1'b1;
    oe_s   = 1'b0;
    bus_s  = 8'h00;
    busy_s = 1'b1;
    done_s = 1'b0;
    rw_s   = func_s[1];
    case (state_s)
      S_IDLE: begin
        busy_s = 1'b0;
        rw_s   = 1'b0;
      end
      S_ADDR: begin
        a_d_s = 1'b0;
        cs_s  = 1'b0;
        wr_s  = 1'b0;
        oe_s  = 1'b1;
        bus_s = addr_s;
      end
      S_GAP1, S_GAP2: begin
        busy_s = 1'b1;
      end
      S_DATA: begin
        cs_s = 1'b0;
        if (func_s[1]) begin
          rd_s = 1'b0;
        end else begin
          wr_s  = 1'b0;
          oe_s  = 1'b1;
          bus_s = dato_s;
        end
      end
      S_DONE: begin
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
        rw_s   = 1'b0;
      end
    endcase
  end

  // State, counter, transaction latches and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= S_IDLE;
      cnt_r           <= CNT_ZERO;
      addr_r          <= 8'h00;
      dato_r          <= 8'h00;
      func_r          <= 2'b00;
      a_d_out         <= 1'b1;
      cs_out          <= 1'b1;
      wr_out          <= 1'b1;
      rd_out          <= 1'b1;
      bus_oe_out      <= 1'b0;
      bus_dato_out    <= 8'h00;
      dato_leido_out  <= 8'h00;
      dato_valido_out <= 1'b0;
      addr_RAM_out    <= 4'd0;
      funcion_r_w_out <= 1'b0;
      busy_out        <= 1'b0;
      done_out        <= 1'b0;
    end else begin
      state_r         <= state_s;
      cnt_r           <= cnt_s;
      addr_r          <= addr_s;
      dato_r          <= dato_s;
      func_r          <= func_s;
      a_d_out         <= a_d_s;
      cs_out          <= cs_s;
      wr_out          <= wr_s;
      rd_out          <= rd_s;
      bus_oe_out      <= oe_s;
      bus_dato_out    <= bus_s;
      dato_leido_out  <= capture_s ? bus_dato_in : dato_leido_out;
      dato_valido_out <= capture_s;
      addr_RAM_out    <= idx_s;
      funcion_r_w_out <= rw_s;
      busy_out        <= busy_s;
      done_out        <= done_s;
    end
  end

endmodule

// File: tb/tb_generador_pulsos_rtc_param.sv
// Scoreboard bench for generador_pulsos_rtc_param (default timing parameters).
module tb_generador_pulsos_rtc_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] funcion;
  logic [7:0] addr_in, dato_wr_in, bus_dato_in;
  logic       a_d_out, cs_out, wr_out, rd_out, bus_oe_out;
  logic [7:0] bus_dato_out, dato_leido_out;
  logic       dato_valido_out, funcion_r_w_out, busy_out, done_out;
  logic [3:0] addr_RAM_out;

  generador_pulsos_rtc_param dut (
    .clk(clk), .rst(rst), .start(start), .funcion(funcion), .addr_in(addr_in),
    .dato_wr_in(dato_wr_in), .bus_dato_in(bus_dato_in), .a_d_out(a_d_out),
    .cs_out(cs_out), .wr_out(wr_out), .rd_out(rd_out), .bus_oe_out(bus_oe_out),
    .bus_dato_out(bus_dato_out), .dato_leido_out(dato_leido_out),
    .dato_valido_out(dato_valido_out), .addr_RAM_out(addr_RAM_out),
    .funcion_r_w_out(funcion_r_w_out), .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [8:0] val; } snap_t;
  typedef struct { logic [7:0] d; logic [3:0] idx; } rd_t;

  snap_t      snap_q[$];
  logic [7:0] addr_q[$];
  logic [7:0] wdata_q[$];
  rd_t        rd_q[$];
  int         done_q[$];

  int total = 0;
  int bad   = 0;
  int cyc_cnt = 0;

  // {a_d, cs, wr, rd, bus_oe, busy, done, dato_valido, funcion_r_w}
  localparam logic [8:0] SNAP_IDLE = 9'b1111_0000_0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic fail_evt(input string nm);
    total = total + 1;
    bad   = bad + 1;
    $display("FAIL %s actual=event required=none", nm);
  endtask

  function automatic logic [7:0] rtc_val(input logic [7:0] a);
    return (a == 8'h04) ? 8'h37 : (a ^ 8'h5A);
  endfunction

  // Expected pins for cycle c (1-based) of a default-timing transaction
  function automatic logic [8:0] exp_snap(input int c, input bit rd);
    logic [7:0] b;
    if (c <= 4)       b = 8'b0001_1100;
    else if (c <= 6)  b = 8'b1111_0100;
    else if (c <= 10) b = rd ? 8'b1010_0100 : 8'b1001_1100;
    else if (c <= 12) b = (rd && c == 11) ? 8'b1111_0101 : 8'b1111_0100;
    else if (c == 13) b = 8'b1111_0110;
    else              b = 8'b1111_0000;
    return {b, (c <= 13) ? rd : 1'b0};
  endfunction

  task automatic push_snap(input int cyc, input logic [8:0] v);
    snap_t s;
    s.cyc = cyc;
    s.val = v;
    snap_q.push_back(s);
  endtask

  // Issue one request; n_keep>0 only queues expectations up to that cycle (aborted op)
  task automatic issue(input logic [1:0] f, input logic [7:0] a, input logic [7:0] d,
                       input int n_keep, output int n0);
    int  nreg;
    bit  rd;
    rd_t r;
    nreg = 1;
`ifdef GEN_PULSOS_BURST_EN
    if (f == 2'b11) nreg = 9;
`endif
    rd = f[1];
    @(posedge clk); #1;
    start = 1'b1; funcion = f; addr_in = a; dato_wr_in = d;
    @(posedge clk); #1;
    start = 1'b0; addr_in = 8'h00; dato_wr_in = 8'h00;
    n0 = cyc_cnt;
    for (int i = 0; i < nreg; i++) begin
      for (int c = 1; c <= 12; c++) begin
        if (n_keep == 0 || 12 * i + c <= n_keep) push_snap(n0 + 12 * i + c - 1, exp_snap(c, rd));
      end
      if (n_keep == 0 || 12 * i + 1 <= n_keep) addr_q.push_back(a + 8'(i));
      if (!rd && (n_keep == 0 || 12 * i + 7 <= n_keep)) wdata_q.push_back(d);
      if (rd && (n_keep == 0 || 12 * i + 11 <= n_keep)) begin
        r.d   = rtc_val(a + 8'(i));
        r.idx = 4'(i);
        rd_q.push_back(r);
      end
    end
    if (n_keep == 0) begin
      push_snap(n0 + 12 * nreg, exp_snap(13, rd));
      push_snap(n0 + 12 * nreg + 1, exp_snap(14, rd));
      done_q.push_back(n0 + 12 * nreg);
    end
  endtask

  task automatic push_idle(input int k);
    for (int i = 0; i < k; i++) push_snap(cyc_cnt + i, SNAP_IDLE);
  endtask

  // RTC model: remembers the address and returns data only in the last read-strobe cycle
  initial begin
    logic [7:0] latched;
    int         rd_cnt;
    latched = 8'h00;
    rd_cnt  = 0;
    bus_dato_in = 8'hEE;
    forever begin
      @(negedge clk);
      if (!cs_out && !a_d_out && bus_oe_out) latched = bus_dato_out;
      if (!rd_out) rd_cnt = rd_cnt + 1;
      else         rd_cnt = 0;
      bus_dato_in = (!rd_out && rd_cnt == 4) ? rtc_val(latched) : 8'hEE;
    end
  end

  // Monitor: pops expectations whenever the DUT presents an event
  initial begin
    logic       prev_cs, prev_ad;
    logic [8:0] act;
    snap_t      s;
    rd_t        r;
    logic [7:0] e;
    int         dc;
    prev_cs = 1'b1;
    prev_ad = 1'b1;
    forever begin
      @(negedge clk);
      act = {a_d_out, cs_out, wr_out, rd_out, bus_oe_out, busy_out, done_out,
             dato_valido_out, funcion_r_w_out};
      while (snap_q.size() > 0 && snap_q[0].cyc < cyc_cnt) begin
        s = snap_q.pop_front();
        fail_evt("snap_missed");
      end
      if (snap_q.size() > 0 && snap_q[0].cyc == cyc_cnt) begin
        s = snap_q.pop_front();
        chk("pins", 32'(act), 32'(s.val));
      end
      if (!cs_out && !a_d_out && !(!prev_cs && !prev_ad)) begin
        if (addr_q.size() == 0) fail_evt("addr_phase_unexpected");
        else begin
          e = addr_q.pop_front();
          chk("addr_bus", {23'd0, bus_oe_out, bus_dato_out}, {23'd0, 1'b1, e});
        end
      end
      if (!cs_out && a_d_out && !wr_out && prev_cs) begin
        if (wdata_q.size() == 0) fail_evt("wdata_phase_unexpected");
        else begin
          e = wdata_q.pop_front();
          chk("wdata_bus", {23'd0, bus_oe_out, bus_dato_out}, {23'd0, 1'b1, e});
        end
      end
      if (dato_valido_out) begin
        if (rd_q.size() == 0) fail_evt("dato_valido_unexpected");
        else begin
          r = rd_q.pop_front();
          chk("read_data", {20'd0, addr_RAM_out, dato_leido_out}, {20'd0, r.idx, r.d});
        end
      end
      if (done_out) begin
        if (done_q.size() == 0) fail_evt("done_unexpected");
        else begin
          dc = done_q.pop_front();
          chk("done_cycle", cyc_cnt, dc);
        end
      end
      if (!wr_out && !rd_out) fail_evt("wr_rd_both_low");
      prev_cs = cs_out;
      prev_ad = a_d_out;
    end
  end

  // Directed stimulus
  initial begin
    int n0;
    int nb;
    rst = 1'b1; start = 1'b0; funcion = 2'b00; addr_in = 8'h00; dato_wr_in = 8'h00;
    nb = 1;
`ifdef GEN_PULSOS_BURST_EN
    nb = 9;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_pins", {25'd0, a_d_out, cs_out, wr_out, rd_out, bus_oe_out, busy_out, done_out},
        {25'd0, 7'b1111_000});
    chk("reset_data", {7'd0, bus_dato_out, dato_leido_out, addr_RAM_out, dato_valido_out, funcion_r_w_out},
        32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single write, with a start pulse while busy that must be ignored
    issue(2'b01, 8'h0A, 8'h5C, 0, n0);
    repeat (3) @(posedge clk); #1;
    start = 1'b1; funcion = 2'b10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk); #1;
    push_idle(3);
    repeat (3) @(posedge clk); #1;

    // single read
    issue(2'b10, 8'h04, 8'hFF, 0, n0);
    repeat (16) @(posedge clk); #1;

    // nop request while idle
    start = 1'b1; funcion = 2'b00; addr_in = 8'h11;
    @(posedge clk); #1;
    start = 1'b0;
    push_idle(4);
    repeat (4) @(posedge clk); #1;

    // burst read (single read when bursts are not compiled in), address wraps
    issue(2'b11, 8'hFE, 8'h00, 0, n0);
    repeat (12 * nb + 4) @(posedge clk); #1;

    // reset in the data phase of a write
    issue(2'b01, 8'h33, 8'h99, 8, n0);
    repeat (7) @(posedge clk); #1;
    rst = 1'b1;
    push_snap(n0 + 8, SNAP_IDLE);
    push_snap(n0 + 9, SNAP_IDLE);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_midop_data", {20'd0, addr_RAM_out, dato_leido_out}, 32'd0);

    // normal write after the abort
    issue(2'b01, 8'hC3, 8'h3C, 0, n0);
    repeat (16) @(posedge clk); #1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("snap_q_empty", snap_q.size(), 0);
    chk("addr_q_empty", addr_q.size(), 0);
    chk("wdata_q_empty", wdata_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
